// File: rtl/arm_mc_pkg.sv
// ============================================================================
// Module  : arm_mc_pkg
// Purpose : Shared definitions for the multicycle ARM control slice.
//           Holds the FSM state encoding, ALU operation codes, condition
//           codes and the datapath mux select values.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package arm_mc_pkg;

  // Main FSM states (4-bit encoding, codes 10-15 are illegal)
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXECR  = 4'd6,
    ST_EXECI  = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9
  } state_e;

  // ALU operation codes. For the six real operations the ALUControl value
  // equals the funct[4:1] opcode. CMP/TST are opcode values only; they are
  // executed as SUB/AND respectively.
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;
  localparam logic [3:0] ALU_MVN = 4'b1111;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam logic [3:0] ALU_TST = 4'b1000;

  // Condition codes (instr[31:28])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Datapath mux selects
  localparam logic [1:0] ALU_SRC_A_RN    = 2'd0;
  localparam logic [1:0] ALU_SRC_A_PC    = 2'd1;
  localparam logic [1:0] ALU_SRC_B_RM    = 2'd0;
  localparam logic [1:0] ALU_SRC_B_IMM   = 2'd1;
  localparam logic [1:0] ALU_SRC_B_FOUR  = 2'd2;
  localparam logic [1:0] RESULT_SRC_ALUOUT = 2'd0;
  localparam logic [1:0] RESULT_SRC_DATA   = 2'd1;
  localparam logic [1:0] RESULT_SRC_ALURES = 2'd2;

endpackage

`default_nettype wire

// File: rtl/arm_cond_unit.sv
// ============================================================================
// Module  : arm_cond_unit
// Purpose : Combinational ARM condition check of instr[31:28] against the
//           registered NZCV flags. Code 1111 never executes.
// Ports   : cond    in  4  condition field
//           flags   in  4  registered {N,Z,C,V}
//           cond_ex out 1  instruction executes
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_cond_unit
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/arm_multicycle_ctrl.sv
// ============================================================================
// Module  : arm_multicycle_ctrl
// Purpose : Multicycle ARM controller: main FSM (FETCH/DECODE/EXEC/MEM/WB),
//           ALU decoder, condition check and the NZCV flag register. Drives
//           a shared-memory multicycle datapath with a ready handshake.
// Ports   : clk, rst_n (async active-low)
//           cond/op/funct/rd       IR fields
//           alu_flags              {N,Z,C,V} from the ALU, current cycle
//           mem_ready              memory access completes this cycle
//           mem_req/mem_w          memory request / write strobe
//           pc_write/ir_write/reg_w  datapath write enables
//           adr_src, alu_src_a/b, result_src, imm_src, reg_src  mux selects
//           alu_control            ALU operation
//           flags_q, state_q       registered NZCV, FSM state (debug)
// Options : `define ARM_MC_CMP_TST_EN adds CMP/TST (flag-only, no writeback)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_multicycle_ctrl
  import arm_mc_pkg::*;
#(
  parameter int ALU_CTRL_W    = 4,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            cond,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            rd,
  input  logic [3:0]            alu_flags,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_w,
  output logic                  ir_write,
  output logic                  reg_w,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [3:0]            flags_q,
  output logic [3:0]            state_q
);

  state_e     state_r, state_nx;
  logic [3:0] flags_r;
  logic       cond_ex;
  logic       done;

  // ALU decode of funct[4:1]; valid whenever the IR holds a DP instruction
  logic [3:0] dp_alu;
  logic       dp_ok;     // recognised opcode
  logic       dp_cmp;    // flag-only compare/test, no writeback
  logic       dp_arith;  // ADD/SUB update C and V

  // Unqualified strobes, gated by rst_n before leaving the block
  logic       mem_req_c, pc_write_c, mem_w_c, ir_write_c, reg_w_c;
  logic [3:0] alu_c;
  logic       is_exec, flag_we;

  assign done    = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign is_exec = (state_r == ST_EXECR) || (state_r == ST_EXECI);

  arm_cond_unit u_cond (
    .cond    (cond),
    .flags   (flags_r),
    .cond_ex (cond_ex)
  );

  always_comb begin
    dp_alu = ALU_ADD;
    dp_ok  = 1'b1;
    dp_cmp = 1'b0;
    case (funct[4:1])
      ALU_ADD, ALU_SUB, ALU_AND,
      ALU_ORR, ALU_MOV, ALU_MVN: dp_alu = funct[4:1];
`ifdef ARM_MC_CMP_TST_EN
      ALU_CMP: begin
        dp_alu = ALU_SUB;
        dp_cmp = 1'b1;
      end
      ALU_TST: begin
        dp_alu = ALU_AND;
        dp_cmp = 1'b1;
      end
`endif
      default: dp_ok = 1'b0;
    endcase
  end

  assign dp_arith = dp_ok && ((dp_alu == ALU_ADD) || (dp_alu == ALU_SUB));
  // CMP/TST imply S; unrecognised opcodes leave the flags alone
  assign flag_we  = is_exec && dp_ok && (funct[0] || dp_cmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
      flags_r <= 4'b0000;
    end else begin
      state_r <= state_nx;
      if (flag_we)
        flags_r <= {alu_flags[3:2], dp_arith ? alu_flags[1:0] : flags_r[1:0]};
    end
  end

  always_comb begin
    state_nx   = state_r;
    mem_req_c  = 1'b0;
    pc_write_c = 1'b0;
    mem_w_c    = 1'b0;
    ir_write_c = 1'b0;
    reg_w_c    = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = ALU_SRC_A_RN;
    alu_src_b  = ALU_SRC_B_RM;
    result_src = RESULT_SRC_ALUOUT;
    alu_c      = ALU_ADD;

    case (state_r)
      ST_FETCH: begin
        mem_req_c  = 1'b1;
        alu_src_a  = ALU_SRC_A_PC;
        alu_src_b  = ALU_SRC_B_FOUR;
        result_src = RESULT_SRC_ALURES;
        if (done) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_nx   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_a = ALU_SRC_A_PC;
        alu_src_b = ALU_SRC_B_FOUR;
        if (!cond_ex) begin
          state_nx = ST_FETCH;
        end else begin
          case (op)
            2'b00:   state_nx = funct[5] ? ST_EXECI : ST_EXECR;
            2'b01:   state_nx = ST_MEMADR;
            2'b10:   state_nx = ST_BRANCH;
            default: state_nx = ST_FETCH;
          endcase
        end
      end
      ST_MEMADR: begin
        alu_src_b = ALU_SRC_B_IMM;
        state_nx  = funct[0] ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        if (done) state_nx = ST_MEMWB;
      end
      ST_MEMWR: begin
        mem_req_c = 1'b1;
        adr_src   = 1'b1;
        mem_w_c   = 1'b1;
        if (done) state_nx = ST_FETCH;
      end
      ST_MEMWB: begin
        reg_w_c    = 1'b1;
        pc_write_c = (rd == 4'd15);
        result_src = RESULT_SRC_DATA;
        state_nx   = ST_FETCH;
      end
      ST_EXECR, ST_EXECI: begin
        alu_src_b = (state_r == ST_EXECI) ? ALU_SRC_B_IMM : ALU_SRC_B_RM;
        alu_c     = dp_alu;
        state_nx  = dp_cmp ? ST_FETCH : ST_ALUWB;
      end
      ST_ALUWB: begin
        // An unrecognised opcode must not commit anything, including R15
        reg_w_c    = dp_ok;
        pc_write_c = dp_ok && (rd == 4'd15);
        result_src = RESULT_SRC_ALUOUT;
        state_nx   = ST_FETCH;
      end
      ST_BRANCH: begin
        pc_write_c = 1'b1;
        alu_src_b  = ALU_SRC_B_IMM;
        result_src = RESULT_SRC_ALURES;
        state_nx   = ST_FETCH;
      end
      default: state_nx = ST_FETCH;
    endcase
  end

  // The register resets asynchronously, but the strobes also have to be
  // quiet during reset even though FETCH normally requests memory.
  assign mem_req  = mem_req_c  & rst_n;
  assign pc_write = pc_write_c & rst_n;
  assign mem_w    = mem_w_c    & rst_n;
  assign ir_write = ir_write_c & rst_n;
  assign reg_w    = reg_w_c    & rst_n;

  assign imm_src = op;
  // reg_src[1]: STR reads Rd as the second operand; reg_src[0]: branch reads R15
  assign reg_src = {(op == 2'b01) && !funct[0], (op == 2'b10)};

  always_comb begin
    alu_control      = '0;
    alu_control[3:0] = alu_c;
  end

  assign flags_q = flags_r;
  assign state_q = state_r;

endmodule

`default_nettype wire

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
- Multicycle successor to the single-cycle ARM control decoder.
- Contains a main control FSM, the ALU decoder, a condition-check unit and the NZCV flag register.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over several cycles against a shared instruction/data memory with a ready handshake.
- Sits between the instruction register and a multicycle datapath: shared ALU, PC and IR write enables.

Parameters:
- ALU_CTRL_W, 4, width of ALUControl; the low 4 bits use the fixed encoding below and upper bits are 0.
- MEM_HANDSHAKE, 1, 1 = memory states wait on mem_ready; 0 = memory always completes in one cycle (mem_ready ignored).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cond  in  4  instr[31:28] from IR.
- op  in  2  instr[27:26].
- funct  in  6  instr[25:20].
- rd  in  4  instr[15:12].
- alu_flags  in  4  {N,Z,C,V} from ALU, current cycle.
- mem_ready  in  1  memory access completes this cycle.
- mem_req  out  1  memory access requested.
- pc_write  out  1  PC load enable.
- adr_src  out  1  0 = PC, 1 = ALU result register.
- mem_w  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- reg_w  out  1  register file write.
- alu_src_a  out  2  0 = Rn, 1 = PC, 2 = reserved.
- alu_src_b  out  2  0 = Rm, 1 = ext imm, 2 = const 4.
- result_src  out  2  0 = ALU out register, 1 = data register, 2 = ALU result.
- imm_src  out  2  immediate format.
- reg_src  out  2  register-read mux selects.
- alu_control  out  ALU_CTRL_W  ALU operation.
- flags_q  out  4  registered NZCV.
- state_q  out  4  FSM state, for debug.

Behaviour:
- **Reset.** Asynchronous, active-low.
  - state_q = FETCH (0); flags_q = 0.
  - While rst_n = 0, every strobe (mem_req, pc_write, ir_write, reg_w, mem_w) is 0.
- **Control outputs.** Combinational from state_q, the IR fields, and mem_ready (for gating only).
- **Flags.** flags_q is the only datapath state held here.
- **States** (4-bit encoding):
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9.
  - Codes 10-15 are illegal and go to FETCH.
- **FETCH**
  - mem_req = 1, adr_src = 0, alu_src_a = 1, alu_src_b = 2, result_src = 2, ADD.
  - ir_write and pc_write assert only in the cycle done = 1, where done = mem_ready when MEM_HANDSHAKE = 1, else done = 1.
  - On done, go to DECODE; otherwise stay in FETCH.
- **DECODE**
  - Computes PC+8 via alu_src_a = 1, alu_src_b = 2.
  - If condEx = 0, go to FETCH with no further writes.
  - Otherwise dispatch on op:
    - op 00 with funct[5] = 1 → EXECI.
    - op 00 with funct[5] = 0 → EXECR.
    - op 01 → MEMADR.
    - op 10 → BRANCH.
    - op 11 → FETCH (unimplemented; no side effects).
- **MEMADR.** ADD with alu_src_b = 1. Next state is MEMRD if funct[0] = 1, else MEMWR.
- **MEMRD.** mem_req = 1, adr_src = 1. Go to MEMWB on done.
- **MEMWR.** mem_req = 1, adr_src = 1; mem_w is asserted for the whole state. Go to FETCH on done.
- **MEMWB.** reg_w = 1, result_src = 1. Go to FETCH.
- **EXECR / EXECI.** ALU decode as below; alu_src_b is 0 or 1 respectively. Go to ALUWB.
- **ALUWB.** reg_w = 1, result_src = 0. Go to FETCH.
- **BRANCH.** pc_write = 1, alu_src_b = 1, ADD, result_src = 2. Go to FETCH.
- **PC-targeted writes.** In ALUWB and MEMWB, if rd = 15, pc_write = 1 in addition to reg_w.
- **ALU decode** (EXECR/EXECI), on funct[4:1]:
  - 0100 ADD = 0100; 0010 SUB = 0010; 0000 AND = 0000; 1100 ORR = 1100; 1101 MOV = 1101; 1111 MVN = 1111.
  - Any other code: alu_control = ADD, and reg_w is suppressed in ALUWB.
  - All non-DP states use ADD (0100).
- **Flag write.** In EXECR/EXECI, if funct[0] = 1, flags_q is updated at the clock edge:
  - N and Z from alu_flags for every DP operation.
  - C and V only for ADD/SUB; otherwise C and V hold.
- **condEx.** Standard ARM cond decode (EQ..LE, AL = 1110) evaluated against flags_q. Code 1111 is treated as false.
- **Reset mid-access.** Aborts immediately; FSM returns to FETCH and no partial write is issued after reset release.

Optional Feature:
- Macro: ARM_MC_CMP_TST_EN.
- Defined:
  - funct[4:1] = 1010 (CMP) decodes as SUB and 1000 (TST) as AND.
  - Flags are always written (S is implied).
  - The FSM goes EXECx → FETCH, skipping ALUWB; reg_w is never asserted for these.
- Undefined: these codes fall under "any other code" above.

Decomposition:
- Package arm_mc_pkg holds:
  - state encoding constants;
  - ALU_ADD/SUB/AND/ORR/MOV/MVN/CMP/TST codes;
  - cond code constants;
  - ALU_SRC/RESULT_SRC select constants.
- Sub-module arm_cond_unit: combinational cond + flags_q → condEx.

Test Plan:
- ADD reg, S = 0, cond AL, MEM_HANDSHAKE = 1, mem_ready held low 3 cycles in FETCH → FETCH ×4, DECODE, EXECR, ALUWB; ir_write one pulse; reg_w in ALUWB; flags_q unchanged.
- SUBS immediate with alu_flags = 0110 → EXECI, then flags_q = 0110; ANDS with alu_flags = 1011 → flags_q N,Z = 1,0 while C,V hold.
- LDR (op 01, funct[0] = 1), rd = 15 → MEMADR, MEMRD, MEMWB; reg_w and pc_write both 1 in MEMWB. STR → mem_w = 1 only in MEMWR, then FETCH.
- BEQ with flags_q Z = 0 → DECODE → FETCH, no pc_write. With Z = 1 → BRANCH, pc_write = 1 for one cycle.
- Assert rst_n = 0 during MEMWR → state_q = 0 and mem_w = 0 immediately. After release: FETCH with flags_q = 0.
- With ARM_MC_CMP_TST_EN, CMP (funct = 010100) → EXECR then FETCH; reg_w never 1; flags updated.
